// File: rtl/uart_result_sequencer_if.sv
// Result-stream and transmitter-handshake bundle for uart_result_sequencer.
// slave: the sequencer; master: upstream pipeline plus the UART transmitter side.
interface uart_result_sequencer_if #(
   parameter int DATA_W = 54,
   parameter int DEPTH  = 16,
   parameter int ELEMS  = 9
);
   logic                       in_valid;
   logic [DATA_W-1:0]          in_data;
   logic                       in_ready;
   logic                       tx_busy;
   logic                       tx_send;
   logic [DATA_W-1:0]          tx_data;
   logic [$clog2(DEPTH):0]     fifo_count;
   logic [$clog2(ELEMS)-1:0]   elem_index;
   logic                       frame_done;
   logic                       overflow;

   modport master (
      output in_valid, in_data, tx_busy,
      input  in_ready, tx_send, tx_data, fifo_count, elem_index, frame_done, overflow
   );

   modport slave (
      input  in_valid, in_data, tx_busy,
      output in_ready, tx_send, tx_data, fifo_count, elem_index, frame_done, overflow
   );
endinterface

// File: rtl/uart_result_sequencer.sv
// FIFO-buffered feeder of matrix results into the UART transmitter; push-to-send latency 2 cycles.
// Backpressure: in_ready drops when full; pushes into a full FIFO are dropped and flag overflow.
module uart_result_sequencer #(
   parameter int DATA_W = 54,
   parameter int DEPTH  = 16,
   parameter int ELEMS  = 9
) (
   input logic                     clk,
   input logic                     rst,
   uart_result_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(ELEMS);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

   state_t             state;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               send_q;
   logic [DATA_W-1:0]  data_q;
   logic [IW-1:0]      idx_q;
   logic               done_q;
   logic               ovf_q;

   // Fullness is taken before any same-cycle pop, so a full FIFO rejects even while draining.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.in_valid && !full;
   assign pop   = (state == LOAD);

   assign bus.in_ready   = !full;
   assign bus.tx_send    = send_q;
   assign bus.tx_data    = data_q;
   assign bus.fifo_count = count;
   assign bus.elem_index = idx_q;
   assign bus.frame_done = done_q;
   assign bus.overflow   = ovf_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (bus.in_valid && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // tx_send/tx_data are loaded on entry to LOAD so they are valid during the LOAD cycle itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         send_q <= 1'b0;
         data_q <= '0;
         idx_q  <= '0;
         done_q <= 1'b0;
      end else begin
         send_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty && !bus.tx_busy) begin
                  state  <= LOAD;
                  send_q <= 1'b1;
                  data_q <= mem[rd_ptr];
               end
            end
            LOAD: begin
               state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (bus.tx_busy) begin
                  state <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!bus.tx_busy) begin
                  if (idx_q == IW'(ELEMS - 1)) begin
                     idx_q  <= '0;
                     done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_result_sequencer.sv
// Bench for uart_result_sequencer: queue scoreboard plus transmitter model, table vectors for fill/overflow.
module tb_uart_result_sequencer;
   localparam int DATA_W = 54;
   localparam int DEPTH  = 16;
   localparam int ELEMS  = 9;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_result_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ELEMS(ELEMS)) bus ();

   uart_result_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ELEMS(ELEMS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [DATA_W-1:0] exp_q[$];
   bit  model_ovf = 1'b0;
   int  sends     = 0;
   int  frames    = 0;
   bit  hold      = 1'b0;
   bit  rnd_busy  = 1'b0;
   int  busy_len  = 20;
   int  busy_left = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Transmitter: busy rises on the edge after it sees send, then stays high busy_len cycles.
   initial begin
      logic s;
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         s = bus.tx_send;
         @(posedge clk);
         #1;
         if (rst) busy_left = 0;
         else if (s) busy_left = rnd_busy ? int'($urandom_range(1, 6)) : busy_len;
         else if (busy_left > 0) busy_left--;
         bus.tx_busy = hold || (busy_left > 0);
      end
   end

   // Reference model: ordered queue of accepted elements, sticky overflow, send/frame counters.
   initial begin
      int occ;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            model_ovf = 1'b0;
            sends     = 0;
            frames    = 0;
         end else begin
            occ = exp_q.size();
            check("fifo_count", bus.fifo_count, occ);
            check("in_ready", bus.in_ready, occ < DEPTH);
            check("overflow", bus.overflow, model_ovf);
            if (bus.frame_done) begin
               frames++;
               check("frame_done_index", bus.elem_index, 0);
            end
            if (bus.tx_send) begin
               check("send_while_busy", bus.tx_busy, 0);
               check("elem_index_at_send", bus.elem_index, sends % ELEMS);
               if (exp_q.size() > 0) check("tx_data_order", bus.tx_data, exp_q.pop_front());
               else check("send_without_data", bus.tx_send, 0);
               sends++;
            end
            if (bus.in_valid) begin
               if (occ < DEPTH) exp_q.push_back(bus.in_data);
               else model_ovf = 1'b1;
            end
         end
      end
   end

   task automatic step(input logic v, input logic [DATA_W-1:0] d);
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int budget);
      int n     = 0;
      int quiet = 0;
      while (quiet < 4 && n < budget) begin
         step(1'b0, '0);
         n++;
         if (bus.fifo_count == 0 && !bus.tx_busy && !bus.tx_send) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) begin
         checks++;
         $display("FAIL drain_timeout: fifo_count=%0d after %0d cycles, required empty and idle", bus.fifo_count, n);
      end
   endtask

   task automatic wait_send(input string name, input int budget);
      int n = 0;
      while (!bus.tx_send && n < budget) begin
         step(1'b0, '0);
         n++;
      end
      check(name, bus.tx_send, 1);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      rst = 1'b0;
      step(1'b0, '0);
   endtask

   typedef struct {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic              exp_ready;
      int                exp_count;
      logic              exp_ovf;
   } vec_t;

   initial begin
      vec_t        tbl[DEPTH + 2];
      logic [63:0] r;
      int          s0;
      int          f0;
      int          pushed;
      int          guard;

      for (int i = 0; i < DEPTH + 1; i++) begin
         tbl[i].valid     = 1'b1;
         tbl[i].data      = DATA_W'(i + 1);
         tbl[i].exp_count = (i + 1 < DEPTH) ? i + 1 : DEPTH;
         tbl[i].exp_ready = (i + 1 < DEPTH);
         tbl[i].exp_ovf   = (i == DEPTH);
      end
      tbl[DEPTH + 1] = '{1'b0, '0, 1'b0, DEPTH, 1'b1};

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_tx_send", bus.tx_send, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_elem_index", bus.elem_index, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      step(1'b0, '0);

      // Fill to full with the transmitter held busy, then one rejected push.
      hold = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         step(tbl[i].valid, tbl[i].data);
         check($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].exp_count);
         check($sformatf("tbl%0d_ready", i), bus.in_ready, tbl[i].exp_ready);
         check($sformatf("tbl%0d_overflow", i), bus.overflow, tbl[i].exp_ovf);
      end
      hold = 1'b0;
      wait_idle(1000);
      check("ovf_drained", sends, DEPTH);
      check("ovf_sticky", bus.overflow, 1);

      // Single element
      apply_reset();
      busy_len = 20;
      step(1'b1, 54'h2A_BCDE_F012_3456);
      check("single_no_early_send", bus.tx_send, 0);
      step(1'b0, '0);
      check("single_send_latency", bus.tx_send, 1);
      check("single_tx_data", bus.tx_data, 54'h2A_BCDE_F012_3456);
      wait_idle(200);
      check("single_sends", sends, 1);
      check("single_elem_index", bus.elem_index, 1);
      check("single_fifo_empty", bus.fifo_count, 0);
      check("single_no_frame", frames, 0);

      // Full frame burst
      apply_reset();
      for (int v = 1; v <= ELEMS; v++) step(1'b1, DATA_W'(v));
      step(1'b0, '0);
      wait_idle(1000);
      check("burst_sends", sends, ELEMS);
      check("burst_frames", frames, 1);
      check("burst_elem_index", bus.elem_index, 0);

      // Randomised stream across pointer wrap
      rnd_busy = 1'b1;
      s0 = sends;
      f0 = frames;
      pushed = 0;
      guard = 0;
      while (pushed < 40 && guard < 3000) begin
         guard++;
         if (bus.in_ready && $urandom_range(0, 1) == 1) begin
            r = {$urandom(), $urandom()};
            step(1'b1, r[DATA_W-1:0]);
            pushed++;
         end else begin
            step(1'b0, '0);
         end
      end
      step(1'b0, '0);
      wait_idle(2000);
      check("wrap_pushed", pushed, 40);
      check("wrap_sends", sends - s0, 40);
      check("wrap_frames", frames - f0, 4);
      check("wrap_elem_index", bus.elem_index, 4);
      rnd_busy = 1'b0;

      // Push on the same cycle as the LOAD pop with three entries queued
      busy_len = 3;
      hold = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      for (int v = 0; v < 3; v++) step(1'b1, DATA_W'(100 + v));
      step(1'b0, '0);
      check("pp_pre_count", bus.fifo_count, 3);
      hold = 1'b0;
      wait_send("pp_load_seen", 20);
      check("pp_load_count", bus.fifo_count, 3);
      step(1'b1, DATA_W'(200));
      check("pp_count_held", bus.fifo_count, 3);
      s0 = sends;
      wait_idle(300);
      check("pp_drained", sends - s0, 3);

      // Reset while waiting for busy to fall, five entries queued
      busy_len = 20;
      hold = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      for (int v = 0; v < 6; v++) step(1'b1, DATA_W'(300 + v));
      step(1'b0, '0);
      hold = 1'b0;
      wait_send("rmid_send_seen", 20);
      repeat (4) step(1'b0, '0);
      check("rmid_queued", bus.fifo_count, 5);
      check("rmid_busy", bus.tx_busy, 1);
      #1;
      rst = 1'b1;
      #1;
      check("rmid_tx_send", bus.tx_send, 0);
      check("rmid_tx_data", bus.tx_data, 0);
      check("rmid_fifo_count", bus.fifo_count, 0);
      check("rmid_elem_index", bus.elem_index, 0);
      check("rmid_frame_done", bus.frame_done, 0);
      check("rmid_overflow", bus.overflow, 0);
      check("rmid_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (30) step(1'b0, '0);
      check("rmid_no_send_after_reset", sends, 0);
      step(1'b1, DATA_W'(77));
      step(1'b0, '0);
      wait_idle(200);
      check("rmid_new_send", sends, 1);
      check("rmid_new_index", bus.elem_index, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end
endmodule
